// File: rtl/pbit_pkg.sv
// Shared types and constants for the p-bit update block.
// Holds the FSM state enum, default widths and the tanh table generator.
package pbit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        HOLD
    } state_t;

    localparam int IN_W_DEF   = 8;
    localparam int TANH_W_DEF = 16;
    localparam int RAND_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int TANH_MAX   = 2 ** (TANH_W_DEF - 1) - 1;

    // Fractional bits used while building the table.
    localparam int FX = 60;

    // Table entry for address idx: tanh of the Q4.(in_w-4) value idx,
    // rounded to nearest Q1.(tanh_w-1) and saturated symmetrically.
    // Works on the magnitude via y = exp(-2|x|), tanh = (1-y)/(1+y),
    // so every intermediate stays in [0,1] and fits 128 bits.
    function automatic int tanh_code(input int idx, input int in_w,
                                     input int tanh_w);
        logic [127:0] one, z, term, pos, neg, base, y, num, den, q;
        int mag, tmax;
        logic is_neg;
        is_neg = (idx >= (1 << (in_w - 1)));
        mag    = is_neg ? (1 << in_w) - idx : idx;
        tmax   = (1 << (tanh_w - 1)) - 1;
        one    = 128'd1 << FX;
        // z = 2 * lsb weight; base = exp(-z) by Taylor series
        z      = (one << 1) >> (in_w - 4);
        term   = one;
        pos    = one;
        neg    = '0;
        for (int n = 1; n <= 40; n++) begin
            term = ((term * z) >> FX) / 128'(n);
            if (n[0]) neg = neg + term;
            else      pos = pos + term;
        end
        base = pos - neg;
        y    = one;
        for (int j = 0; j < mag; j++) y = (y * base) >> FX;
        den = one + y;
        num = (one - y) << (tanh_w - 1);
        q   = ((num << 1) + den) / (den << 1);
        if (q > 128'(tmax)) q = 128'(tmax);
        return is_neg ? -int'(q) : int'(q);
    endfunction

endpackage

// File: rtl/pbit_tanh_lut.sv
// Synchronous tanh ROM: q = tanh(addr) one cycle after addr.
// Ports: clk, rst (async low), addr (field as unsigned), q (signed Q1.x).
module pbit_tanh_lut
    import pbit_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int TANH_W = TANH_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   addr,
    output logic [TANH_W-1:0] q
);

    logic [TANH_W-1:0] rom [2**IN_W];

    for (genvar i = 0; i < 2 ** IN_W; i++) begin : g_rom
        assign rom[i] = TANH_W'(tanh_code(i, IN_W, TANH_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= rom[addr];
    end

endmodule

// File: rtl/pbit_update.sv
// P-bit update: m = sgn(tanh(I) - r), one LFSR word consumed per field.
// Ports: clk, rst (async low), field_in/valid/ready, rand_in, lfsr_en,
// pbit_out/valid/ready; ones_count only when PBIT_STATS_EN is defined.
module pbit_update
    import pbit_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int TANH_W = TANH_W_DEF,
`ifdef PBIT_STATS_EN
    parameter int CNT_W  = CNT_W_DEF,
`endif
    parameter int RAND_W = RAND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   field_in,
    input  logic              field_valid,
    output logic              field_ready,
    input  logic [RAND_W-1:0] rand_in,
    output logic              lfsr_en,
    output logic              pbit_out,
    output logic              pbit_valid,
    input  logic              pbit_ready
`ifdef PBIT_STATS_EN
    ,
    output logic [CNT_W-1:0]  ones_count
`endif
);

    state_t            state, state_nx;
    logic [IN_W-1:0]   field_reg;
    logic [TANH_W-1:0] tanh_q;
    logic              gt;

    // Only the top TANH_W bits of the LFSR word are used.
    logic unused_rand;
    assign unused_rand = ^rand_in[RAND_W-TANH_W-1:0];

    pbit_tanh_lut #(
        .IN_W   (IN_W),
        .TANH_W (TANH_W)
    ) u_lut (
        .clk  (clk),
        .rst  (rst),
        .addr (field_reg),
        .q    (tanh_q)
    );

    // Tie (tanh == r) yields -1.
    assign gt = $signed(tanh_q) > $signed(rand_in[RAND_W-1 -: TANH_W]);

    always_comb begin
        state_nx    = state;
        field_ready = 1'b0;
        lfsr_en     = 1'b0;
        pbit_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                field_ready = 1'b1;
                if (field_valid) state_nx = LOOKUP;
            end
            LOOKUP:  state_nx = COMPARE;
            COMPARE: begin
                lfsr_en  = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                pbit_valid = 1'b1;
                if (pbit_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            field_reg <= '0;
            pbit_out  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && field_valid) field_reg <= field_in;
            if (state == COMPARE)             pbit_out  <= gt;
        end
    end

`ifdef PBIT_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_count <= '0;
        end else if (state == HOLD && pbit_ready && pbit_out) begin
            ones_count <= ones_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pbit_update.sv
// Self-checking bench for pbit_update: directed vector table plus
// backpressure, mid-op reset and (with PBIT_STATS_EN) statistics runs.
module tb_pbit_update;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  field_in;
    logic        field_valid;
    logic        field_ready;
    logic [31:0] rand_in;
    logic        lfsr_en;
    logic        pbit_out;
    logic        pbit_valid;
    logic        pbit_ready;
`ifdef PBIT_STATS_EN
    logic [15:0] ones_count;
`endif

    int nchk;
    int nfail;

    always #5 clk = ~clk;

    pbit_update dut (
        .clk         (clk),
        .rst         (rst),
        .field_in    (field_in),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .rand_in     (rand_in),
        .lfsr_en     (lfsr_en),
        .pbit_out    (pbit_out),
        .pbit_valid  (pbit_valid),
        .pbit_ready  (pbit_ready)
`ifdef PBIT_STATS_EN
        ,
        .ones_count  (ones_count)
`endif
    );

    // Bench LFSR model: Galois x^32+x^22+x^2+x+1, 32 shifts per word.
    logic [31:0] lfsr = 32'hACE1_2468;

    function automatic logic [31:0] lfsr_word(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int k = 0; k < 32; k++)
            v = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
        return v;
    endfunction

    always @(posedge clk) if (lfsr_en) lfsr <= lfsr_word(lfsr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts #1 after an edge in IDLE; that edge is "N".
    task automatic run_one(input logic [7:0] f, input logic [31:0] r,
                           input logic exp_p, input string nm);
        int en;
        en = 0;
        chk({nm, "_ready"}, field_ready, 1'b1);
        field_in    = f;
        rand_in     = r;
        field_valid = 1'b1;
        @(posedge clk); #1;
        field_valid = 1'b0;
        en += int'(lfsr_en);
        @(posedge clk); #1;
        en += int'(lfsr_en);
        chk({nm, "_valid_n2"}, pbit_valid, 1'b0);
        @(posedge clk); #1;
        en += int'(lfsr_en);
        chk({nm, "_valid_n3"}, pbit_valid, 1'b1);
        chk({nm, "_pbit"}, pbit_out, exp_p);
        chk({nm, "_lfsr_en"}, en, 1);
        pbit_ready = 1'b1;
        @(posedge clk); #1;
        pbit_ready = 1'b0;
        chk({nm, "_valid_fall"}, pbit_valid, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  f;
        logic [31:0] r;
        logic        p;
        string       nm;
    } vec_t;

    vec_t vecs [11];

    initial begin
        nchk        = 0;
        nfail       = 0;
        field_in    = '0;
        field_valid = 1'b0;
        rand_in     = '0;
        pbit_ready  = 1'b0;

        // tanh(0.5)*32768 = 15142.65 -> 15143 (0x3B27); -0.5 -> 0xC4D9
        vecs[0]  = '{8'h7F, 32'h0000_0000, 1'b1, "sat_pos"};
        vecs[1]  = '{8'h80, 32'h0000_0000, 1'b0, "sat_neg"};
        vecs[2]  = '{8'h00, 32'h0001_0000, 1'b0, "zero_rpos"};
        vecs[3]  = '{8'h00, 32'h0000_0000, 1'b0, "zero_tie"};
        vecs[4]  = '{8'h00, 32'hFFFF_0000, 1'b1, "zero_rneg"};
        vecs[5]  = '{8'h08, 32'h3B26_0000, 1'b1, "half_below"};
        vecs[6]  = '{8'h08, 32'h3B27_0000, 1'b0, "half_tie"};
        vecs[7]  = '{8'h80, 32'h8000_0000, 1'b1, "sat_neg_vs_min"};
        vecs[8]  = '{8'hF8, 32'hC4D8_0000, 1'b1, "mhalf_below"};
        vecs[9]  = '{8'hF8, 32'hC4D9_0000, 1'b0, "mhalf_tie"};
        vecs[10] = '{8'h7F, 32'h7FFF_FFFF, 1'b0, "sat_pos_tie"};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_field_ready", field_ready, 1'b1);
        chk("rst_pbit_valid", pbit_valid, 1'b0);
        chk("rst_pbit_out", pbit_out, 1'b0);
        chk("rst_lfsr_en", lfsr_en, 1'b0);
`ifdef PBIT_STATS_EN
        chk("rst_ones", ones_count, 16'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_one(vecs[i].f, vecs[i].r, vecs[i].p, vecs[i].nm);

        // Backpressure: hold pbit_ready low in HOLD for 10 cycles.
        field_in    = 8'h7F;
        rand_in     = 32'h0;
        field_valid = 1'b1;
        @(posedge clk); #1;
        field_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        field_in    = 8'h80;
        field_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", pbit_valid, 1'b1);
            chk("bp_pbit", pbit_out, 1'b1);
            chk("bp_field_ready", field_ready, 1'b0);
            chk("bp_lfsr_en", lfsr_en, 1'b0);
            @(posedge clk); #1;
        end
        field_valid = 1'b0;
        pbit_ready  = 1'b1;
        @(posedge clk); #1;
        pbit_ready = 1'b0;
        chk("bp_release_valid", pbit_valid, 1'b0);
        chk("bp_release_idle", field_ready, 1'b1);
        run_one(8'h00, 32'hFFFF_0000, 1'b1, "after_bp");

        // Reset asserted while in LOOKUP.
        field_in    = 8'h7F;
        rand_in     = 32'h0;
        field_valid = 1'b1;
        @(posedge clk); #1;
        field_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", field_ready, 1'b1);
        chk("mid_rst_valid", pbit_valid, 1'b0);
        chk("mid_rst_pbit", pbit_out, 1'b0);
        chk("mid_rst_lfsr_en", lfsr_en, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mid_rst_hold_en", lfsr_en, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", pbit_valid, 1'b0);
        run_one(8'h80, 32'h0000_0000, 1'b0, "post_rst");

`ifdef PBIT_STATS_EN
        begin
            int en_tot;
            int bad;
            int ones_m;
            logic exp_p;
            en_tot = 0;
            bad    = 0;
            ones_m = 0;
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            chk("stats_cleared", ones_count, 16'd0);
            for (int u = 0; u < 1000; u++) begin
                int en;
                en          = 0;
                rand_in     = lfsr;
                exp_p       = (int'($signed(lfsr[31:16])) < 15143);
                ones_m     += int'(exp_p);
                field_in    = 8'h08;
                field_valid = 1'b1;
                @(posedge clk); #1;
                field_valid = 1'b0;
                en += int'(lfsr_en);
                @(posedge clk); #1;
                en += int'(lfsr_en);
                @(posedge clk); #1;
                en += int'(lfsr_en);
                if (pbit_out !== exp_p || en != 1) bad++;
                en_tot += en;
                pbit_ready = 1'b1;
                @(posedge clk); #1;
                pbit_ready = 1'b0;
            end
            chk("stats_updates_ok", bad, 0);
            chk("stats_lfsr_en_total", en_tot, 1000);
            chk("stats_ones_model", ones_count, ones_m);
            chk("stats_ones_range",
                (ones_count >= 16'd682 && ones_count <= 16'd772), 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nchk, nfail);
        $finish;
    end

endmodule
